// File: rtl/conv_window_gen.sv
// ---------------------------------------------------------------------------
// conv_window_gen
//
// Streaming 3x3 window generator for the convolution array. Pixels arrive in
// raster order as 12-bit RGB444 words. The two previous image rows live in two
// line buffers (lb1 = row r-1, lb0 = row r-2). For every interior pixel
// position a registered 3x3 neighbourhood is emitted as three 36-bit row
// words. One frame is processed per start command; done pulses once the last
// window has been taken by the consumer.
//
// Row word packing: [11:0] = column c-2, [23:12] = c-1, [35:24] = c (newest).
//
// Handshake rule (both streams): a transfer happens on a rising clk edge where
// valid && ready are both high. A producer holding valid keeps its payload
// stable until the transfer happens.
//
// Ports:
//   clk        sole clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   start      begins a frame, only looked at in IDLE
//   in_pixel   input pixel, [11:8] R, [7:4] G, [3:0] B
//   in_valid   in_pixel is valid
//   in_ready   block accepts in_pixel this cycle
//   pixel_in0  top window row (image row r-2)
//   pixel_in1  middle window row (r-1)
//   pixel_in2  bottom window row (r)
//   out_col    column of the window centre (c-1)
//   out_row    row of the window centre (r-1)
//   out_valid  window outputs are valid
//   out_ready  consumer takes the window
//   out_last   final window of the frame
//   done       one-cycle pulse at frame completion
//   dbg_state  current FSM state (0 IDLE, 1 ACTIVE, 2 DRAIN)
// ---------------------------------------------------------------------------
module conv_window_gen #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [11:0]                in_pixel,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [35:0]                pixel_in0,
    output logic [35:0]                pixel_in1,
    output logic [35:0]                pixel_in2,
    output logic [$clog2(IMG_W)-1:0]   out_col,
    output logic [$clog2(IMG_H)-1:0]   out_row,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       done,
    output logic [1:0]                 dbg_state
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Line buffers are deliberately not reset: every entry is rewritten by
    // rows 0 and 1 of a frame before any window can read it.
    logic [11:0] lb0 [IMG_W];
    logic [11:0] lb1 [IMG_W];

    logic [11:0] lb0_rd;
    logic [11:0] lb1_rd;

    // Only the two older columns of each window row need storing; the newest
    // column comes straight from the pixel / line-buffer read.
    logic [23:0] hist0;
    logic [23:0] hist1;
    logic [23:0] hist2;

    logic [35:0] row0_nxt;
    logic [35:0] row1_nxt;
    logic [35:0] row2_nxt;

    logic accept;
    logic last_px;
    logic emit;
    logic last_hs;

    // -----------------------------------------------------------------------
    // Handshake and per-pixel decode
    // -----------------------------------------------------------------------
    assign in_ready = (state == ACTIVE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign last_px  = (row == ROW_LAST) && (col == COL_LAST);
    assign emit     = accept && (row >= RW'(2)) && (col >= CW'(2));
    assign last_hs  = out_valid && out_ready && out_last;

    assign dbg_state = state;

    // Reads see the contents from before this cycle's write.
    assign lb0_rd = lb0[col];
    assign lb1_rd = lb1[col];

    // Post-shift window rows for the pixel being accepted.
    assign row0_nxt = {lb0_rd,   hist0};
    assign row1_nxt = {lb1_rd,   hist1};
    assign row2_nxt = {in_pixel, hist2};

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (accept && last_px) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // The final window was loaded as the FSM entered DRAIN; wait
                // until the consumer takes it.
                if (last_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Position counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if ((state == IDLE) && start) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Line buffers: each accepted pixel pushes the column down by one row.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col] <= lb1_rd;
            lb1[col] <= in_pixel;
        end
    end

    // -----------------------------------------------------------------------
    // Horizontal history. Columns left over from the previous row are
    // pushed out by the time c=2, so no explicit clear at row start.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist0 <= '0;
            hist1 <= '0;
            hist2 <= '0;
        end else if (accept) begin
            hist0 <= row0_nxt[35:12];
            hist1 <= row1_nxt[35:12];
            hist2 <= row2_nxt[35:12];
        end
    end

    // -----------------------------------------------------------------------
    // Output window register. A new window may load in the same cycle the
    // previous one is taken, giving one window per cycle with no bubble.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel_in0 <= '0;
            pixel_in1 <= '0;
            pixel_in2 <= '0;
            out_col   <= '0;
            out_row   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (emit) begin
            pixel_in0 <= row0_nxt;
            pixel_in1 <= row1_nxt;
            pixel_in2 <= row2_nxt;
            out_col   <= col - CW'(1);
            out_row   <= row - RW'(1);
            out_valid <= 1'b1;
            out_last  <= last_px;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    // done follows the out_last handshake by one cycle, coinciding with the
    // return to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= (state == DRAIN) && last_hs;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// ---------------------------------------------------------------------------
// tb_conv_window_gen
//
// Two instances: a 4x4 one for the detailed frame scenarios and a 320x5 one
// for full-width row wrap, throughput and back-to-back frames. Expected
// windows are built straight from the stored image: window at (r,c) is the
// 3x3 block of rows r-2..r, columns c-2..c.
// ---------------------------------------------------------------------------
module tb_conv_window_gen;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- small DUT (4x4) ----------------
    logic        s_start, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic        s_out_last, s_done;
    logic [11:0] s_in_pixel;
    logic [35:0] s_p0, s_p1, s_p2;
    logic [1:0]  s_out_col, s_out_row, s_dbg;

    conv_window_gen #(.IMG_W(4), .IMG_H(4)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start),
        .in_pixel(s_in_pixel), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .pixel_in0(s_p0), .pixel_in1(s_p1), .pixel_in2(s_p2),
        .out_col(s_out_col), .out_row(s_out_row), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_last(s_out_last), .done(s_done),
        .dbg_state(s_dbg)
    );

    // ---------------- big DUT (320x5) ----------------
    logic        b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic        b_out_last, b_done;
    logic [11:0] b_in_pixel;
    logic [35:0] b_p0, b_p1, b_p2;
    logic [8:0]  b_out_col;
    logic [2:0]  b_out_row;
    logic [1:0]  b_dbg;

    conv_window_gen #(.IMG_W(320), .IMG_H(5)) u_big (
        .clk(clk), .rst_n(rst_n), .start(b_start),
        .in_pixel(b_in_pixel), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .pixel_in0(b_p0), .pixel_in1(b_p1), .pixel_in2(b_p2),
        .out_col(b_out_col), .out_row(b_out_row), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_last(b_out_last), .done(b_done),
        .dbg_state(b_dbg)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;

    logic [11:0]  frm [0:1][0:4][0:319];
    logic [127:0] exp_s[$];
    logic [127:0] exp_b[$];

    int s_win_cnt = 0, b_win_cnt = 0, s_done_cnt = 0, b_done_cnt = 0;
    bit first_chk = 0;
    int rdy_mode = 0;
    int bp_left = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [127:0] win(input int d, input int r, input int c,
                                         input int w, input int h);
        logic [35:0] rw [3];
        for (int k = 0; k < 3; k++)
            rw[k] = {frm[d][r-2+k][c], frm[d][r-2+k][c-1], frm[d][r-2+k][c-2]};
        return {2'b00, rw[0], rw[1], rw[2], 9'(c - 1), 8'(r - 1),
                1'((r == h - 1) && (c == w - 1))};
    endfunction

    task automatic load_exp(input int d, input int w, input int h);
        for (int r = 2; r < h; r++)
            for (int c = 2; c < w; c++)
                if (d == 0) exp_s.push_back(win(d, r, c, w, h));
                else        exp_b.push_back(win(d, r, c, w, h));
    endtask

    task automatic fill(input int d, input bit rnd);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 320; c++)
                frm[d][r][c] = rnd ? 12'($urandom) : 12'((r << 4) | c);
    endtask

    function automatic logic [127:0] s_word();
        return {2'b00, s_p0, s_p1, s_p2, 9'(s_out_col), 8'(s_out_row), s_out_last};
    endfunction

    function automatic logic [127:0] b_word();
        return {2'b00, b_p0, b_p1, b_p2, 9'(b_out_col), 8'(b_out_row), b_out_last};
    endfunction

    // ---------------- monitors ----------------
    logic         s_last_prev = 0, s_hold_prev = 0, b_last_prev = 0;
    logic [127:0] s_prev_word = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            s_last_prev = 0;
            s_hold_prev = 0;
        end else begin
            if (s_done || s_last_prev)
                check("s_done_pulse", 128'(s_done), 128'(s_last_prev));
            if (s_done) s_done_cnt++;
            if (s_hold_prev) check("s_hold", s_word(), s_prev_word);
            if (s_out_valid && !s_out_ready)
                check("s_bp_in_ready", 128'(s_in_ready), 128'(0));
            if (s_out_valid && s_out_ready) begin
                if (first_chk) begin
                    check("first_p0", 128'(s_p0), 128'(36'h002001000));
                    check("first_p1", 128'(s_p1), 128'(36'h012011010));
                    check("first_p2", 128'(s_p2), 128'(36'h022021020));
                    check("first_col", 128'(s_out_col), 128'(1));
                    check("first_row", 128'(s_out_row), 128'(1));
                    first_chk = 0;
                end
                if (exp_s.size() == 0) check("s_extra_win", s_word(), 128'(0));
                else check("s_win", s_word(), exp_s.pop_front());
                s_win_cnt++;
            end
            s_last_prev = s_out_valid && s_out_ready && s_out_last;
            s_hold_prev = s_out_valid && !s_out_ready;
            s_prev_word = s_word();
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            b_last_prev = 0;
        end else begin
            if (b_done || b_last_prev)
                check("b_done_pulse", 128'(b_done), 128'(b_last_prev));
            if (b_done) b_done_cnt++;
            if (b_out_valid && b_out_ready) begin
                if (exp_b.size() == 0) check("b_extra_win", b_word(), 128'(0));
                else check("b_win", b_word(), exp_b.pop_front());
                b_win_cnt++;
            end
            b_last_prev = b_out_valid && b_out_ready && b_out_last;
        end
    end

    // ---------------- out_ready driver (small DUT) ----------------
    initial begin
        s_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: s_out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (s_out_valid && bp_left > 0) begin
                        s_out_ready = 1'b0;
                        bp_left--;
                    end else begin
                        s_out_ready = 1'b1;
                    end
                end
                default: s_out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_s();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
    endtask

    task automatic send_small(input int gap_max, input bit poke_start, input int n_pix);
        bit acc;
        int budget;
        for (int i = 0; i < n_pix; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                s_in_valid = 1'b0;
                s_in_pixel = 12'($urandom);
                tick();
            end
            s_in_pixel = frm[0][i / 4][i % 4];
            s_in_valid = 1'b1;
            s_start    = poke_start && (i == 5);
            acc = 0;
            budget = 0;
            while (!acc) begin
                @(negedge clk);
                acc = s_in_ready;
                tick();
                s_start = 1'b0;
                budget++;
                if (!acc && budget > 100) begin
                    check("s_accept_timeout", 128'(0), 128'(1));
                    s_in_valid = 1'b0;
                    return;
                end
            end
        end
        s_in_valid = 1'b0;
    endtask

    task automatic frame_small(input int gap_max, input bit poke_start);
        int d0, n;
        s_win_cnt = 0;
        load_exp(0, 4, 4);
        d0 = s_done_cnt;
        pulse_start_s();
        send_small(gap_max, poke_start, 16);
        // Keep offering junk while draining and idle: it must be ignored.
        s_in_valid = 1'b1;
        s_in_pixel = 12'($urandom);
        n = 0;
        while (s_done_cnt == d0 && n < 100) begin
            @(negedge clk);
            check("s_drain_in_ready", 128'(s_in_ready), 128'(0));
            tick();
            n++;
        end
        s_in_valid = 1'b0;
        repeat (3) tick();
        check("s_done_cnt", 128'(s_done_cnt - d0), 128'(1));
        check("s_win_cnt", 128'(s_win_cnt), 128'(4));
        check("s_leftover", 128'(exp_s.size()), 128'(0));
    endtask

    task automatic check_reset_s();
        check("rst_in_ready", 128'(s_in_ready), 128'(0));
        check("rst_out_valid", 128'(s_out_valid), 128'(0));
        check("rst_out_last", 128'(s_out_last), 128'(0));
        check("rst_done", 128'(s_done), 128'(0));
        check("rst_word", s_word(), 128'(0));
        check("rst_state", 128'(s_dbg), 128'(0));
    endtask

    task automatic frame_big();
        int d0, n, i;
        bit acc;
        b_win_cnt = 0;
        load_exp(1, 320, 5);
        d0 = b_done_cnt;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_in_valid = 1'b1;
        i = 0;
        n = 0;
        while (i < 1600 && n < 5000) begin
            b_in_pixel = frm[1][i / 320][i % 320];
            @(negedge clk);
            acc = b_in_ready;
            tick();
            if (acc) i++;
            n++;
        end
        b_in_valid = 1'b0;
        check("b_thru_cycles", 128'(n), 128'(1600));
        n = 0;
        while (b_done_cnt == d0 && n < 50) begin
            tick();
            n++;
        end
        check("b_done_seen", 128'(b_done_cnt - d0), 128'(1));
        check("b_win_cnt", 128'(b_win_cnt), 128'(318 * 3));
        check("b_leftover", 128'(exp_b.size()), 128'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        s_start = 1'b0; s_in_valid = 1'b0; s_in_pixel = '0;
        b_start = 1'b0; b_in_valid = 1'b0; b_in_pixel = '0; b_out_ready = 1'b1;
        repeat (3) tick();
        check_reset_s();
        rst_n = 1'b1;
        tick();

        // in_valid in IDLE is never accepted
        s_in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_in_pixel = 12'($urandom);
            @(negedge clk);
            check("idle_in_ready", 128'(s_in_ready), 128'(0));
            tick();
        end
        s_in_valid = 1'b0;

        // basic frame
        fill(0, 0);
        rdy_mode = 0;
        first_chk = 1;
        frame_small(0, 0);
        check("first_seen", 128'(first_chk), 128'(0));

        // backpressure after the first window
        rdy_mode = 2;
        bp_left = 5;
        frame_small(0, 0);
        check("bp_used", 128'(bp_left), 128'(0));

        // bubbly input, random out_ready, start poked mid-frame
        rdy_mode = 1;
        frame_small(3, 1);

        // random pixel frames
        for (int f = 0; f < 3; f++) begin
            fill(0, 1);
            frame_small(2, f[0]);
        end

        // reset mid-frame at pixel 9
        fill(0, 0);
        rdy_mode = 0;
        begin
            int d0;
            d0 = s_done_cnt;
            pulse_start_s();
            send_small(0, 0, 9);
            rst_n = 1'b0;
            tick();
            check_reset_s();
            check("rst_col", 128'(s_out_col), 128'(0));
            rst_n = 1'b1;
            exp_s.delete();
            repeat (6) tick();
            check("rst_no_done", 128'(s_done_cnt - d0), 128'(0));
        end
        frame_small(0, 0);

        // full-width frames back to back
        fill(1, 1);
        frame_big();
        fill(1, 1);
        frame_big();
        repeat (3) tick();
        check("b_total_done", 128'(b_done_cnt), 128'(2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 window generator that feeds the convolution array of the image coprocessor. It accepts a raster-order stream of 12-bit RGB444 pixels and keeps the two previous image rows in internal line buffers. For every interior pixel position it emits one registered 3x3 neighbourhood as three 36-bit row words, packed exactly as the convolution array consumes them. One frame is processed per `start` command, and `done` is pulsed when the last window has been accepted.

## Interface
Parameters:
- `IMG_W`, 320: image width in pixels (min 3).
- `IMG_H`, 240: image height in rows (min 3).

Ports:
- `clk`  in  1  sole clock; all logic is posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begins a frame; sampled only in IDLE.
- `in_pixel`  in  12  pixel: [11:8] R, [7:4] G, [3:0] B.
- `in_valid`  in  1  `in_pixel` is valid.
- `in_ready`  out  1  block accepts `in_pixel` this cycle.
- `pixel_in0`  out  36  top window row (image row r-2).
- `pixel_in1`  out  36  middle window row (r-1).
- `pixel_in2`  out  36  bottom window row (r).
- `out_col`  out  $clog2(IMG_W)  column of the window centre (c-1).
- `out_row`  out  $clog2(IMG_H)  row of the window centre (r-1).
- `out_valid`  out  1  window outputs are valid.
- `out_ready`  in  1  consumer takes the window.
- `out_last`  out  1  marks the final window of the frame.
- `done`  out  1  one-cycle pulse at frame completion.

## Operation
- Row word packing:
  - [11:0] holds column c-2, [23:12] holds c-1, [35:24] holds c (newest).
  - Channel nibbles sit at the same positions inside each 12-bit field.
- States:
  - IDLE: `in_ready`=0. `start`=1 clears `col`/`row` to 0 and moves to ACTIVE.
  - ACTIVE: accepts pixels. Accepting pixel (row=IMG_H-1, col=IMG_W-1) moves to DRAIN.
  - DRAIN: `in_ready`=0. When the final window handshakes, pulse `done` and return to IDLE.
- Accept condition: `in_valid && in_ready`. `in_ready` = ACTIVE && (!out_valid || out_ready).
- On each accept of pixel p at (r,c):
  - Read `lb1[c]` (row r-1) and `lb0[c]` (row r-2).
  - Write `lb0[c]` <= old `lb1[c]` and `lb1[c]` <= p. Reads see pre-write contents.
  - Shift each row register: row2 <= {p, row2[35:12]}, row1 <= {lb1[c], row1[35:12]}, row0 <= {lb0[c], row0[35:12]}.
  - Counters: col increments. At IMG_W-1, col wraps to 0 and row increments.
- Window emission:
  - If r>=2 and c>=2, load the output registers from the post-shift rows.
  - Set `out_col`=c-1, `out_row`=r-1, `out_valid`=1.
  - Set `out_last`=1 iff r=IMG_H-1 and c=IMG_W-1.
- Otherwise no window is emitted. Stale columns are flushed naturally by c=2, and rows 0-1 only fill the buffers.
- Windows per frame: (IMG_W-2)*(IMG_H-2), in raster order.
- Output register:
  - `out_valid` clears on `out_ready` unless a new window loads the same cycle.
  - While `out_valid && !out_ready`, all window outputs hold stable.
- Ignored inputs: `start` outside IDLE, and `in_valid` outside ACTIVE.
- Line buffers: IMG_W x 12 each, not cleared by reset. Their contents are never visible before they are rewritten.

## Timing
- Reset values: state=IDLE, `in_ready`=0, `out_valid`=0, `out_last`=0, `done`=0. `pixel_in0/1/2`=0, `out_col`=0, `out_row`=0, counters=0.
- Reset mid-frame: the partial frame is abandoned and no `done` is produced. The next frame needs a new `start`.
- Latency: the window appears one cycle after the accept of its bottom-right pixel.
- Throughput: one pixel and one window per cycle when `out_ready` is held high.
- `start` to ACTIVE takes 1 cycle; `in_ready` can first be 1 in the cycle after `start`.
- `done` asserts in the cycle after the `out_last` handshake, for exactly 1 cycle, as the state returns to IDLE.
- A new window loads in the same cycle the previous one is accepted, so there is no bubble.

## Test plan
Let p(r,c)=(r<<4)|c in all scenarios.
- **Basic frame** (IMG_W=4, IMG_H=4, `out_ready`=1, stream 16 pixels):
  - Exactly 4 windows are produced.
  - First window: `pixel_in0`=36'h002001000, `pixel_in1`=36'h012011010, `pixel_in2`=36'h022021020, `out_col`=1, `out_row`=1.
  - Last window: centre (2,2), `out_last`=1, followed by a `done` pulse.
- **Backpressure** (hold `out_ready`=0 for 5 cycles after the first window):
  - `in_ready`=0 throughout and the outputs hold stable.
  - After release, the remaining windows arrive in order with none lost or duplicated.
- **Bubbly input** (random `in_valid` gaps): window contents and count are identical to the basic-frame run.
- **Reset mid-frame** (assert `rst_n`=0 at pixel 9):
  - All outputs return to their reset values and no `done` is produced.
  - A new `start` plus a full frame produces the correct 4 windows.
- **Ignored controls**:
  - `start` during ACTIVE has no effect.
  - `in_valid` in IDLE is not accepted and `in_ready` stays 0.
- **Default size** (IMG_W=320, IMG_H=240, back-to-back frames): 318*238 = 75684 windows per frame, one `done` per frame, and row wrap is correct at col 319.
